vend_change_dispenser: RTL and testbench
========================================

Name: vend_change_dispenser

Overview:
- Change-return side of the vending controller. The coin FSM accepts coin_5/coin_10 pulses; this block issues coins back out.
- Takes a change amount in cents and drives a coin hopper with one-coin-at-a-time eject pulses, waiting for a hopper acknowledge after each.
- Greedy: 10s first, then 5s. Reports done or error to the vending controller.

Parameters:
- AMT_W, 8, width of the change amount in cents.
- ACK_TIMEOUT, 16, cycles WAIT_ACK waits for hopper_ack before error (≥2).
- CNT_W, 6, width of the coins_issued counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request change; sampled only in IDLE.
- change_amt  input  AMT_W  cents owed; latched on accepted start.
- hopper_ack  input  1  hopper confirms one coin physically ejected.
- eject_5  output  1  one-cycle pulse: eject one 5-cent coin.
- eject_10  output  1  one-cycle pulse: eject one 10-cent coin.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  sticky fault flag; cleared by the next accepted start or by reset.
- coins_issued  output  CNT_W  coins acknowledged in the current or last transaction; saturates at all-ones.

Behaviour:
- Reset: async, active-high. State IDLE, remaining=0, timer=0, coins_issued=0, all outputs 0. Asserting reset mid-transaction aborts immediately; no further eject pulses.
- States: IDLE, ISSUE, WAIT_ACK, DONE, ERR.
- IDLE, start=1 at an edge: latch remaining=change_amt, clear error, clear coins_issued. Then:
  - change_amt mod 5 ≠ 0 → ERR.
  - change_amt = 0 → DONE.
  - otherwise → ISSUE.
- start outside IDLE is ignored.
- ISSUE lasts one cycle:
  - eject_10=1 if remaining ≥ 10, else eject_5=1. Outputs are Moore-decoded, so exactly one is high, for exactly one cycle.
  - Records coin value (cur_coin) → WAIT_ACK with timer cleared.
  - First eject appears the cycle after the accepting start edge.
- WAIT_ACK:
  - hopper_ack=1: remaining -= cur_coin, coins_issued += 1 (saturating). Then → DONE if the new remaining = 0, else → ISSUE.
  - No ack: timer += 1. When timer reaches ACK_TIMEOUT-1 without ack → ERR. Remaining is kept, so the unissued amount is not lost.
  - hopper_ack is only honoured in WAIT_ACK. Ack in IDLE, ISSUE, DONE or ERR is ignored.
  - Ack on the same edge as timeout: ack wins.
- DONE: done=1 for one cycle → IDLE.
- ERR: error set (stays high in IDLE until the next start) → IDLE next cycle.
- Minimum cost is 2 cycles per coin. Example: 25 cents → 10,10,5 → 3 coins, done 7 cycles after start (ack returned immediately).
- Width: remaining is AMT_W bits; the subtraction never underflows because of the ≥10 check and the mod-5 check. The mod-5 check is combinational on change_amt.

Optional Feature:
- Macro: VEND_CHANGE_STOCK_EN.
- Defined: adds input port hopper10_empty (1 bit).
  - In ISSUE, if hopper10_empty=1, issue eject_5 even when remaining ≥ 10. A 10 owed is paid as two 5s.
  - The flag is sampled in each ISSUE cycle, so it may change mid-transaction.
- Undefined: port absent; pure greedy 10-first behaviour.

Decomposition:
- Package vend_pkg:
  - State enum: IDLE, ISSUE, WAIT_ACK, DONE, ERR.
  - Constants COIN5_VAL=5 and COIN10_VAL=10.
  - Coin-select encoding, shared with the coin-acceptor FSM's coin values.
- One sub-module, vend_ack_timer:
  - Clear/enable counter with a terminal flag at ACK_TIMEOUT-1.
  - Instantiated by the FSM for WAIT_ACK.

Test Plan:
- Reset 1 for 10 ns, then start with change_amt=25, ack 1 cycle after each eject:
  - Pulses eject_10, eject_10, eject_5 in that order; one done pulse.
  - coins_issued=3, busy low afterwards, error=0.
- change_amt=0, start → done pulse 1 cycle later; no eject pulses; coins_issued=0.
- change_amt=13, start → no eject; error=1 and held through IDLE. Then start with change_amt=5 → error clears, one eject_5, done.
- change_amt=20, hopper_ack never asserted:
  - One eject_10, then error after ACK_TIMEOUT cycles; no second eject.
  - Next start recovers normally.
- change_amt=255 with immediate acks:
  - 25×eject_10 then 1×eject_5, coins_issued=26, done.
  - Assert reset mid-run → all outputs 0 asynchronously; state IDLE.
- With VEND_CHANGE_STOCK_EN defined, change_amt=30, hopper10_empty=1 after the first coin:
  - Sequence eject_10, eject_5, eject_5, eject_5, eject_5; coins_issued=5.
- Throughout: start pulsed while busy has no effect; stray hopper_ack in IDLE has no effect.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending-controller types: FSM states, coin values and the coin-select encoding
// used by both the coin acceptor and the change dispenser.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_ACK = 3'd2,
        DONE     = 3'd3,
        ERR      = 3'd4
    } state_t;

    localparam int COIN5_VAL  = 5;
    localparam int COIN10_VAL = 10;

    typedef enum logic {
        COIN_SEL_5  = 1'b0,
        COIN_SEL_10 = 1'b1
    } coin_sel_t;

    function automatic int coin_value(input coin_sel_t sel);
        return (sel == COIN_SEL_10) ? COIN10_VAL : COIN5_VAL;
    endfunction

endpackage

// File: rtl/vend_ack_timer.sv
// Hopper acknowledge timer: clear/enable counter that holds at its terminal count
// of ACK_TIMEOUT-1 and flags it.
module vend_ack_timer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(ACK_TIMEOUT - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !term) begin
            count <= count + TW'(1);
        end
    end

    assign term = (count == LAST);

endmodule

// File: rtl/vend_change_dispenser.sv
// Change dispenser: pays out a cent amount greedily as 10s then 5s, one hopper eject at a time.
// Optional VEND_CHANGE_STOCK_EN adds hopper10_empty, which forces 5-cent coins while set.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amt,
    input  logic             hopper_ack,
`ifdef VEND_CHANGE_STOCK_EN
    input  logic             hopper10_empty,
`endif
    output logic             eject_5,
    output logic             eject_10,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] coins_issued
);

    localparam logic [AMT_W-1:0] FIVE = AMT_W'(COIN5_VAL);
    localparam logic [AMT_W-1:0] TEN  = AMT_W'(COIN10_VAL);

    state_t           state;
    state_t           next_state;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] coin_amt;
    logic [AMT_W-1:0] rem_next;
    coin_sel_t        cur_coin;
    logic [CNT_W-1:0] coins_q;
    logic             error_q;
    logic             amt_bad;
    logic             amt_zero;
    logic             use_ten;
    logic             timer_clr;
    logic             timer_en;
    logic             timer_term;

    assign amt_bad  = (change_amt % FIVE) != '0;
    assign amt_zero = (change_amt == '0);
    assign coin_amt = AMT_W'(coin_value(cur_coin));
    assign rem_next = remaining - coin_amt;

`ifdef VEND_CHANGE_STOCK_EN
    assign use_ten = (remaining >= TEN) && !hopper10_empty;
`else
    assign use_ten = (remaining >= TEN);
`endif

    // The timer only runs while waiting on the hopper; leaving WAIT_ACK rearms it.
    assign timer_clr = (state != WAIT_ACK);
    assign timer_en  = (state == WAIT_ACK) && !hopper_ack;

    vend_ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk  (clk),
        .reset(reset),
        .clr  (timer_clr),
        .en   (timer_en),
        .term (timer_term)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        eject_5    = 1'b0;
        eject_10   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (amt_bad) begin
                        next_state = ERR;
                    end else if (amt_zero) begin
                        next_state = DONE;
                    end else begin
                        next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                eject_10   = use_ten;
                eject_5    = !use_ten;
                next_state = WAIT_ACK;
            end
            WAIT_ACK: begin
                // An ack arriving on the timeout edge still counts as a delivered coin.
                if (hopper_ack) begin
                    next_state = (rem_next == '0) ? DONE : ISSUE;
                end else if (timer_term) begin
                    next_state = ERR;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            ERR: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            cur_coin  <= COIN_SEL_5;
            coins_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= change_amt;
                        coins_q   <= '0;
                    end
                end
                ISSUE: begin
                    cur_coin <= use_ten ? COIN_SEL_10 : COIN_SEL_5;
                end
                WAIT_ACK: begin
                    if (hopper_ack) begin
                        remaining <= rem_next;
                        if (coins_q != '1) begin
                            coins_q <= coins_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Error is sticky from entry into ERR until the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (next_state == ERR) begin
            error_q <= 1'b1;
        end else if ((state == IDLE) && start) begin
            error_q <= 1'b0;
        end
    end

    assign error        = error_q;
    assign coins_issued = coins_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed plus randomized bench for vend_change_dispenser against an arithmetic payout model.
module tb_vend_change_dispenser;

    localparam int AMT_W       = 8;
    localparam int ACK_TIMEOUT = 16;
    localparam int CNT_W       = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [AMT_W-1:0] change_amt = '0;
    logic             hopper_ack = 1'b0;
`ifdef VEND_CHANGE_STOCK_EN
    logic             hopper10_empty = 1'b0;
`endif
    logic             eject_5;
    logic             eject_10;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] coins_issued;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vend_change_dispenser #(
        .AMT_W      (AMT_W),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .change_amt    (change_amt),
        .hopper_ack    (hopper_ack),
`ifdef VEND_CHANGE_STOCK_EN
        .hopper10_empty(hopper10_empty),
`endif
        .eject_5       (eject_5),
        .eject_10      (eject_10),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .coins_issued  (coins_issued)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Greedy payout: as many 10s as fit, then one 5 if an odd five remains.
    function automatic void greedy(input int amt, output int q[$]);
        q = {};
        for (int i = 0; i < amt / 10; i++) q.push_back(10);
        if ((amt % 10) >= 5) q.push_back(5);
    endfunction

    // One transaction: the bench plays the hopper, acking each eject after a random delay.
    task automatic run_txn(input string tag, input int amt, input int exp_q[$], input bit expect_err,
                           input int max_delay, input bit never_ack, input bit stock_switch,
                           input bit noise);
        int got[$];
        int exp_cyc;
        int cyc;
        int cnt;
        int dones;
        bit waiting;
        bit finished;
        bit both;
        int d;
        @(negedge clk);
        change_amt = AMT_W'(amt);
        start      = 1'b1;
        hopper_ack = 1'b0;
        @(negedge clk);
        start    = 1'b0;
        exp_cyc  = 1;
        cyc      = 1;
        cnt      = 0;
        dones    = 0;
        waiting  = 1'b0;
        finished = 1'b0;
        both     = 1'b0;
        while (!finished && cyc < 3000) begin
            hopper_ack = 1'b0;
            if (noise) start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (eject_10 && eject_5) both = 1'b1;
            if (eject_10 || eject_5) begin
                got.push_back(eject_10 ? 10 : 5);
                if (never_ack) begin
                    exp_cyc += 1 + ACK_TIMEOUT;
                end else begin
                    d = $urandom_range(0, max_delay);
                    exp_cyc += 2 + d;
                    cnt = d;
                    waiting = 1'b1;
                end
                if (noise) hopper_ack = 1'($urandom_range(0, 1));
            end else if (waiting) begin
                if (cnt == 0) begin
                    hopper_ack = 1'b1;
                    waiting = 1'b0;
`ifdef VEND_CHANGE_STOCK_EN
                    if (stock_switch && got.size() == 1) hopper10_empty = 1'b1;
`endif
                end else begin
                    cnt--;
                end
            end
            if (done) dones++;
            if (done || error) begin
                finished = 1'b1;
                if (noise) hopper_ack = 1'($urandom_range(0, 1));
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, "_finished"}, 32'(finished), 1);
        chk({tag, "_end_cycle"}, cyc, exp_cyc);
        chk({tag, "_ncoins"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_coin%0d", tag, i), got[i], exp_q[i]);
        chk({tag, "_done_pulses"}, dones, expect_err ? 0 : 1);
        chk({tag, "_both_eject"}, 32'(both), 0);
        @(negedge clk);
        start      = 1'b0;
        hopper_ack = 1'b0;
        chk({tag, "_busy_after"}, 32'(busy), 0);
        chk({tag, "_done_after"}, 32'(done), 0);
        chk({tag, "_error_after"}, 32'(error), 32'(expect_err));
        chk({tag, "_coins_issued"}, 32'(coins_issued), expect_err ? 0 : exp_q.size());
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog observed=still_running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int q[$];
        int empty_q[$];
        int amt;
        bit bad;
        bit seen;
        empty_q = {};

        #7;
        chk("rst_eject_5", 32'(eject_5), 0);
        chk("rst_eject_10", 32'(eject_10), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_coins", 32'(coins_issued), 0);
        #3;
        reset = 1'b0;

        greedy(25, q);
        run_txn("amt25", 25, q, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Stray ack while idle must not touch the count or start anything.
        @(negedge clk);
        hopper_ack = 1'b1;
        @(negedge clk);
        hopper_ack = 1'b0;
        chk("stray_ack_busy", 32'(busy), 0);
        chk("stray_ack_eject", 32'(eject_5 | eject_10), 0);
        chk("stray_ack_coins", 32'(coins_issued), 3);

        run_txn("amt0", 0, empty_q, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        run_txn("amt13", 13, empty_q, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("err_held_idle", 32'(error), 1);
        greedy(5, q);
        run_txn("amt5", 5, q, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        q = {10};
        run_txn("noack20", 20, q, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        greedy(35, q);
        run_txn("recover35", 35, q, 1'b0, 2, 1'b0, 1'b0, 1'b0);

        greedy(255, q);
        run_txn("amt255", 255, q, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            bad = ($urandom_range(0, 5) == 0);
            amt = 5 * $urandom_range(0, 45);
            if (bad) begin
                amt = amt + $urandom_range(1, 4);
                q = {};
            end else begin
                greedy(amt, q);
            end
            run_txn($sformatf("rnd%0d", i), amt, q, bad, (i % 4 == 0) ? ACK_TIMEOUT - 1 : 3,
                    1'b0, 1'b0, 1'b1);
        end

        // Mid-run reset: hold ack high so coins flow, then reset while an eject is showing.
        @(negedge clk);
        change_amt = AMT_W'(255);
        start      = 1'b1;
        hopper_ack = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (eject_10 && coins_issued >= 4) seen = 1'b1;
        end
        chk("midrst_reached", 32'(seen), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_eject_5", 32'(eject_5), 0);
        chk("midrst_eject_10", 32'(eject_10), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_error", 32'(error), 0);
        chk("midrst_coins", 32'(coins_issued), 0);
        @(negedge clk);
        hopper_ack = 1'b0;
        reset      = 1'b0;
        repeat (2) @(negedge clk);
        chk("postrst_idle", 32'(busy | eject_5 | eject_10), 0);
        greedy(15, q);
        run_txn("postrst15", 15, q, 1'b0, 1, 1'b0, 1'b0, 1'b0);

`ifdef VEND_CHANGE_STOCK_EN
        q = {10, 5, 5, 5, 5};
        run_txn("stock30", 30, q, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        hopper10_empty = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
